execute_stage: RTL and testbench

- Pipeline stage directly downstream of decode.
- Latches decoded fields and operand values on the valid/allow_in handshake, then computes the RV32IM ALU result (`e_valE`), branch/jump outcome and memory address.
- Resolves predictions: drives `fact_success`, the redirect PC and the flush condition consumed by decode and fetch.
- DIV/DIVU/REM/REMU use a multi-cycle radix-2 divider that stalls the stage; all other operations are single-cycle.

---
 rtl/execute_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_execute_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32IM execute stage with branch resolution and radix-2 divider
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   d_to_e_valid / e_allow_in         decode -> execute handshake
//   m_allow_in / e_to_m_valid         execute -> memory handshake
//   e_valid                           stage occupancy
//   D_*, d_val1, d_val2               decoded fields and forwarded operands
//   E_*                               registered copies for downstream stages
//   e_valE                            ALU / address / MUL / DIV result
//   e_is_jump_instr, fact_success,
//   e_redirect_pc, e_actual_taken     prediction resolution for fetch/decode/predictor
module execute_stage #(
    parameter int N = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          d_to_e_valid,
    output logic          e_allow_in,
    input  logic          m_allow_in,
    output logic          e_to_m_valid,
    output logic          e_valid,
    input  logic [31:0]   D_pc,
    input  logic [31:0]   D_default_pc,
    input  logic [31:0]   D_pred_pc,
    input  logic [31:0]   D_imm,
    input  logic [6:0]    D_opcode,
    input  logic [4:0]    D_rd,
    input  logic [9:0]    D_funct,
    input  logic          D_is_jump_instr,
    input  logic          D_pred_taken,
    input  logic [N-1:0]  D_pred_history,
    input  logic [31:0]   d_val1,
    input  logic [31:0]   d_val2,
    output logic [31:0]   E_pc,
    output logic [31:0]   E_default_pc,
    output logic [6:0]    E_opcode,
    output logic [4:0]    E_rd,
    output logic [9:0]    E_funct,
    output logic [31:0]   E_imm,
    output logic [31:0]   E_val2,
    output logic [N-1:0]  E_pred_history,
    output logic [31:0]   e_valE,
    output logic          e_is_jump_instr,
    output logic          fact_success,
    output logic [31:0]   e_redirect_pc,
    output logic          e_actual_taken
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    logic [31:0] e_pred_pc_q, e_val1_q;
    logic        e_is_jump_q, e_valid_q, redirected_q;
    div_state_t  div_state_q;
    logic [4:0]  div_cnt_q;
    logic [31:0] div_a_q, div_b_q, div_r_q;
    logic        div_neg_q_q, div_neg_r_q;

    // Prediction direction is carried by pred_pc; the flag itself is not needed here.
    logic unused_pred_taken;
    assign unused_pred_taken = D_pred_taken;

    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_mext, is_div, e_ready_go;
    assign funct3  = E_funct[2:0];
    assign funct7  = E_funct[9:3];
    assign is_mext = (E_opcode == OP_R) && (funct7 == 7'b0000001);
    assign is_div  = is_mext && funct3[2];

    assign e_ready_go   = ~is_div | (div_state_q == DIV_DONE);
    assign e_valid      = e_valid_q;
    assign e_allow_in   = ~e_valid_q | (e_ready_go & m_allow_in);
    assign e_to_m_valid = e_valid_q & e_ready_go;

    // ALU
    logic [31:0] alu_b, alu_res;
    logic [4:0]  shamt;
    assign alu_b = (E_opcode == OP_R) ? E_val2 : E_imm;
    assign shamt = alu_b[4:0];
    always_comb begin
        alu_res = 32'd0;
        case (funct3)
            3'b000:  alu_res = ((E_opcode == OP_R) && E_funct[8]) ? e_val1_q - alu_b : e_val1_q + alu_b;
            3'b001:  alu_res = e_val1_q << shamt;
            3'b010:  alu_res = {31'd0, $signed(e_val1_q) < $signed(alu_b)};
            3'b011:  alu_res = {31'd0, e_val1_q < alu_b};
            3'b100:  alu_res = e_val1_q ^ alu_b;
            3'b101:  alu_res = E_funct[8] ? 32'($signed(e_val1_q) >>> shamt) : e_val1_q >> shamt;
            3'b110:  alu_res = e_val1_q | alu_b;
            default: alu_res = e_val1_q & alu_b;
        endcase
    end

    // Multiplier: extend each operand to 64 bits by its signedness; the low 64 bits of the
    // product are then correct for every MUL variant.
    logic [63:0] mul_a, mul_b, mul_prod;
    assign mul_a    = (funct3 == 3'b001 || funct3 == 3'b010) ? {{32{e_val1_q[31]}}, e_val1_q} : {32'd0, e_val1_q};
    assign mul_b    = (funct3 == 3'b001) ? {{32{E_val2[31]}}, E_val2} : {32'd0, E_val2};
    assign mul_prod = mul_a * mul_b;

    // Divider results; divide-by-zero is patched explicitly since the sign fixup would mangle it.
    logic [32:0] div_shift, div_diff;
    logic [31:0] div_quot, div_rem;
    assign div_shift = {div_r_q, div_a_q[31]};
    assign div_diff  = div_shift - {1'b0, div_b_q};
    assign div_quot  = (E_val2 == 32'd0) ? 32'hFFFF_FFFF : (div_neg_q_q ? -div_a_q : div_a_q);
    assign div_rem   = (E_val2 == 32'd0) ? e_val1_q : (div_neg_r_q ? -div_r_q : div_r_q);

    always_comb begin
        e_valE = 32'd0;
        case (E_opcode)
            OP_R: begin
                if (is_mext) begin
                    case (funct3)
                        3'b000:  e_valE = mul_prod[31:0];
                        3'b001,
                        3'b010,
                        3'b011:  e_valE = mul_prod[63:32];
                        3'b100,
                        3'b101:  e_valE = div_quot;
                        default: e_valE = div_rem;
                    endcase
                end else begin
                    e_valE = alu_res;
                end
            end
            OP_I:               e_valE = alu_res;
            OP_LUI:             e_valE = E_imm;
            OP_AUIPC:           e_valE = E_pc + E_imm;
            OP_JAL, OP_JALR:    e_valE = E_default_pc;
            OP_LOAD, OP_STORE:  e_valE = e_val1_q + E_imm;
            default:            e_valE = 32'd0;
        endcase
    end

    // Branch / jump resolution
    logic        br_cond, taken;
    logic [31:0] target, actual_next;
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = (e_val1_q == E_val2);
            3'b001:  br_cond = (e_val1_q != E_val2);
            3'b100:  br_cond = ($signed(e_val1_q) < $signed(E_val2));
            3'b101:  br_cond = ($signed(e_val1_q) >= $signed(E_val2));
            3'b110:  br_cond = (e_val1_q < E_val2);
            3'b111:  br_cond = (e_val1_q >= E_val2);
            default: br_cond = 1'b0;
        endcase
    end
    assign target = (E_opcode == OP_JALR) ? ((e_val1_q + E_imm) & ~32'd1) : (E_pc + E_imm);
    assign taken  = e_is_jump_q &
                    ((E_opcode == OP_JAL) | (E_opcode == OP_JALR) | ((E_opcode == OP_BR) & br_cond));
    assign actual_next     = taken ? target : E_default_pc;
    assign fact_success    = ~e_is_jump_q | redirected_q | (actual_next == e_pred_pc_q);
    assign e_redirect_pc   = actual_next;
    assign e_actual_taken  = taken;
    assign e_is_jump_instr = e_is_jump_q;

    // Pipeline registers; E_* are deliberately unreset and qualified by e_valid.
    always_ff @(posedge clk) begin
        if (e_allow_in && d_to_e_valid) begin
            E_pc           <= D_pc;
            E_default_pc   <= D_default_pc;
            e_pred_pc_q    <= D_pred_pc;
            E_imm          <= D_imm;
            E_opcode       <= D_opcode;
            E_rd           <= D_rd;
            E_funct        <= D_funct;
            e_is_jump_q    <= D_is_jump_instr;
            E_pred_history <= D_pred_history;
            e_val1_q       <= d_val1;
            E_val2         <= d_val2;
        end
    end

    // Occupancy and one-shot redirect: a held mispredicted instruction flushes only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_q    <= 1'b0;
            redirected_q <= 1'b0;
        end else begin
            if (e_allow_in) begin
                e_valid_q    <= d_to_e_valid;
                redirected_q <= 1'b0;
            end else if (e_valid_q && !fact_success) begin
                redirected_q <= 1'b1;
            end
        end
    end

    // Radix-2 restoring divider on magnitudes; quotient bits shift into div_a_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= 5'd0;
        end else begin
            case (div_state_q)
                DIV_IDLE: begin
                    if (e_valid_q && is_div) begin
                        div_a_q     <= (!funct3[0] && e_val1_q[31]) ? -e_val1_q : e_val1_q;
                        div_b_q     <= (!funct3[0] && E_val2[31]) ? -E_val2 : E_val2;
                        div_r_q     <= 32'd0;
                        div_neg_q_q <= !funct3[0] && (e_val1_q[31] ^ E_val2[31]);
                        div_neg_r_q <= !funct3[0] && e_val1_q[31];
                        div_cnt_q   <= 5'd0;
                        div_state_q <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (!div_diff[32]) begin
                        div_r_q <= div_diff[31:0];
                        div_a_q <= {div_a_q[30:0], 1'b1};
                    end else begin
                        div_r_q <= div_shift[31:0];
                        div_a_q <= {div_a_q[30:0], 1'b0};
                    end
                    div_cnt_q <= div_cnt_q + 5'd1;
                    if (div_cnt_q == 5'd31) begin
                        div_state_q <= DIV_DONE;
                    end
                end
                default: begin
                    if (e_to_m_valid && m_allow_in) begin
                        div_state_q <= DIV_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_to_e_valid, e_allow_in, m_allow_in, e_to_m_valid, e_valid;
    logic [31:0] D_pc, D_default_pc, D_pred_pc, D_imm;
    logic [6:0]  D_opcode;
    logic [4:0]  D_rd;
    logic [9:0]  D_funct;
    logic        D_is_jump_instr, D_pred_taken;
    logic [11:0] D_pred_history;
    logic [31:0] d_val1, d_val2;
    logic [31:0] E_pc, E_default_pc, E_imm, E_val2;
    logic [6:0]  E_opcode;
    logic [4:0]  E_rd;
    logic [9:0]  E_funct;
    logic [11:0] E_pred_history;
    logic [31:0] e_valE, e_redirect_pc;
    logic        e_is_jump_instr, fact_success, e_actual_taken;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    execute_stage #(.N(12)) dut (
        .clk(clk), .rst(rst),
        .d_to_e_valid(d_to_e_valid), .e_allow_in(e_allow_in),
        .m_allow_in(m_allow_in), .e_to_m_valid(e_to_m_valid), .e_valid(e_valid),
        .D_pc(D_pc), .D_default_pc(D_default_pc), .D_pred_pc(D_pred_pc), .D_imm(D_imm),
        .D_opcode(D_opcode), .D_rd(D_rd), .D_funct(D_funct),
        .D_is_jump_instr(D_is_jump_instr), .D_pred_taken(D_pred_taken),
        .D_pred_history(D_pred_history), .d_val1(d_val1), .d_val2(d_val2),
        .E_pc(E_pc), .E_default_pc(E_default_pc), .E_opcode(E_opcode), .E_rd(E_rd),
        .E_funct(E_funct), .E_imm(E_imm), .E_val2(E_val2), .E_pred_history(E_pred_history),
        .e_valE(e_valE), .e_is_jump_instr(e_is_jump_instr), .fact_success(fact_success),
        .e_redirect_pc(e_redirect_pc), .e_actual_taken(e_actual_taken)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic jmp, input logic [31:0] ppc);
        D_opcode        = op;
        D_funct         = {f7, f3};
        D_pc            = pc;
        D_default_pc    = pc + 32'd4;
        D_pred_pc       = ppc;
        D_pred_taken    = (ppc != pc + 32'd4);
        D_imm           = imm;
        d_val1          = v1;
        d_val2          = v2;
        D_is_jump_instr = jmp;
        D_rd            = 5'd7;
        D_pred_history  = 12'hA5C;
        d_to_e_valid    = 1'b1;
    endtask

    // Drive one instruction, let it enter the stage, then stop offering new ones.
    task automatic issue(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] v1, input logic [31:0] v2,
                         input logic jmp, input logic [31:0] ppc);
        drive(op, f7, f3, pc, imm, v1, v2, jmp, ppc);
        tick();
        d_to_e_valid = 1'b0;
    endtask

    // Count cycles the stage refuses input, bounded at 100.
    task automatic wait_stall(output int stall);
        stall = 0;
        while (!e_allow_in && stall < 100) begin
            stall++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; d_to_e_valid = 1'b0; m_allow_in = 1'b1;
        drive(OP_I, 7'd0, 3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd4);
        d_to_e_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        total_cnt++;
        if (e_valid !== 1'b0) $display("FAIL reset_e_valid: got %b want 0", e_valid); else pass_cnt++;
        total_cnt++;
        if (e_allow_in !== 1'b1) $display("FAIL reset_allow_in: got %b want 1", e_allow_in); else pass_cnt++;
        total_cnt++;
        if (e_to_m_valid !== 1'b0) $display("FAIL reset_to_m_valid: got %b want 0", e_to_m_valid); else pass_cnt++;
    endtask

    task automatic test_add();
        issue(OP_R, 7'd0, 3'b000, 32'h100, 32'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h104);
        total_cnt++;
        if (e_to_m_valid !== 1'b1) $display("FAIL add_to_m_valid: got %b want 1", e_to_m_valid); else pass_cnt++;
        total_cnt++;
        if (e_valE !== 32'h8000_0000) $display("FAIL add_result: got %h want 80000000", e_valE); else pass_cnt++;
        total_cnt++;
        if (E_rd !== 5'd7 || E_val2 !== 32'd1 || E_pred_history !== 12'hA5C)
            $display("FAIL add_e_regs: got rd=%0d val2=%h hist=%h want rd=7 val2=1 hist=a5c", E_rd, E_val2, E_pred_history);
        else pass_cnt++;
        total_cnt++;
        if (fact_success !== 1'b1) $display("FAIL add_fact_success: got %b want 1", fact_success); else pass_cnt++;
        tick();
        total_cnt++;
        if (e_valid !== 1'b0) $display("FAIL add_drained: got %b want 0", e_valid); else pass_cnt++;
    endtask

    task automatic test_alu();
        issue(OP_R, 7'b0100000, 3'b000, 32'h0, 32'd0, 32'd3, 32'd5, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'hFFFF_FFFE) $display("FAIL alu_sub: got %h want fffffffe", e_valE); else pass_cnt++;
        issue(OP_R, 7'b0100000, 3'b101, 32'h0, 32'd0, 32'h8000_0000, 32'h24, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'hF800_0000) $display("FAIL alu_sra: got %h want f8000000", e_valE); else pass_cnt++;
        issue(OP_R, 7'd0, 3'b010, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'd1) $display("FAIL alu_slt: got %h want 1", e_valE); else pass_cnt++;
        issue(OP_R, 7'd0, 3'b011, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'd0) $display("FAIL alu_sltu: got %h want 0", e_valE); else pass_cnt++;
        issue(OP_I, 7'd0, 3'b001, 32'h0, 32'h21, 32'h0000_0003, 32'd0, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'h0000_0006) $display("FAIL alu_slli: got %h want 6", e_valE); else pass_cnt++;
        issue(OP_LOAD, 7'd0, 3'b010, 32'h0, 32'hFFFF_FFFC, 32'h1000, 32'd0, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'h0000_0FFC) $display("FAIL load_addr: got %h want 00000ffc", e_valE); else pass_cnt++;
        issue(OP_LUI, 7'd0, 3'b000, 32'h0, 32'hABCD_E000, 32'd0, 32'd0, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'hABCD_E000) $display("FAIL lui: got %h want abcde000", e_valE); else pass_cnt++;
        tick();
    endtask

    task automatic test_mul();
        issue(OP_R, 7'd1, 3'b000, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'd1) $display("FAIL mul_low: got %h want 1", e_valE); else pass_cnt++;
        issue(OP_R, 7'd1, 3'b001, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'd0) $display("FAIL mulh: got %h want 0", e_valE); else pass_cnt++;
        issue(OP_R, 7'd1, 3'b011, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'hFFFF_FFFE) $display("FAIL mulhu: got %h want fffffffe", e_valE); else pass_cnt++;
        issue(OP_R, 7'd1, 3'b010, 32'h0, 32'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h4);
        total_cnt++;
        if (e_valE !== 32'hFFFF_FFFF) $display("FAIL mulhsu: got %h want ffffffff", e_valE); else pass_cnt++;
        tick();
    endtask

    task automatic test_branch();
        m_allow_in = 1'b0;
        issue(OP_BR, 7'd0, 3'b000, 32'h8000_0010, 32'h20, 32'd5, 32'd5, 1'b1, 32'h8000_0014);
        total_cnt++;
        if (fact_success !== 1'b0) $display("FAIL beq_mispredict: got %b want 0", fact_success); else pass_cnt++;
        total_cnt++;
        if (e_redirect_pc !== 32'h8000_0030) $display("FAIL beq_redirect_pc: got %h want 80000030", e_redirect_pc); else pass_cnt++;
        total_cnt++;
        if (e_actual_taken !== 1'b1) $display("FAIL beq_taken: got %b want 1", e_actual_taken); else pass_cnt++;
        total_cnt++;
        if (e_to_m_valid !== 1'b1 || e_allow_in !== 1'b0)
            $display("FAIL beq_stall_hs: got to_m=%b allow=%b want 1/0", e_to_m_valid, e_allow_in);
        else pass_cnt++;
        for (int c = 2; c <= 3; c++) begin
            tick();
            total_cnt++;
            if (fact_success !== 1'b1) $display("FAIL beq_oneshot_cycle%0d: got %b want 1", c, fact_success); else pass_cnt++;
        end
        m_allow_in = 1'b1;
        // Correctly predicted not-taken BNE
        issue(OP_BR, 7'd0, 3'b001, 32'h200, 32'h40, 32'd5, 32'd5, 1'b1, 32'h204);
        total_cnt++;
        if (fact_success !== 1'b1 || e_actual_taken !== 1'b0)
            $display("FAIL bne_not_taken: got fs=%b taken=%b want 1/0", fact_success, e_actual_taken);
        else pass_cnt++;
        issue(OP_JALR, 7'd0, 3'b000, 32'h300, 32'd0, 32'h8000_1003, 32'd0, 1'b1, 32'h8000_1002);
        total_cnt++;
        if (fact_success !== 1'b1) $display("FAIL jalr_lsb: got %b want 1", fact_success); else pass_cnt++;
        // Mispredicted JAL after the earlier redirect: the one-shot flag must be clear again
        issue(OP_JAL, 7'd0, 3'b000, 32'h100, 32'h40, 32'd0, 32'd0, 1'b1, 32'h104);
        total_cnt++;
        if (fact_success !== 1'b0 || e_redirect_pc !== 32'h140)
            $display("FAIL jal_redirect: got fs=%b pc=%h want 0/00000140", fact_success, e_redirect_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_div();
        int stall;
        issue(OP_R, 7'd1, 3'b100, 32'h0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h4);
        wait_stall(stall);
        total_cnt++;
        if (stall !== 33) $display("FAIL div_stall_cycles: got %0d want 33", stall); else pass_cnt++;
        total_cnt++;
        if (e_to_m_valid !== 1'b1) $display("FAIL div_to_m_valid: got %b want 1", e_to_m_valid); else pass_cnt++;
        total_cnt++;
        if (e_valE !== 32'h8000_0000) $display("FAIL div_overflow: got %h want 80000000", e_valE); else pass_cnt++;
        tick();
        issue(OP_R, 7'd1, 3'b100, 32'h0, 32'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h4);
        wait_stall(stall);
        total_cnt++;
        if (e_valE !== 32'hFFFF_FFFD) $display("FAIL div_signed: got %h want fffffffd", e_valE); else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int stall;
        issue(OP_R, 7'd1, 3'b111, 32'h0, 32'd0, 32'd7, 32'd0, 1'b0, 32'h4);
        wait_stall(stall);
        total_cnt++;
        if (stall !== 33 || e_valE !== 32'd7)
            $display("FAIL remu_by_zero: got stall=%0d val=%h want 33/00000007", stall, e_valE);
        else pass_cnt++;
        // DIVU loads on the same edge REMU leaves
        issue(OP_R, 7'd1, 3'b101, 32'h0, 32'd0, 32'd100, 32'd7, 1'b0, 32'h4);
        wait_stall(stall);
        total_cnt++;
        if (stall !== 33 || e_valE !== 32'd14)
            $display("FAIL divu_b2b: got stall=%0d val=%h want 33/0000000e", stall, e_valE);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_div();
        int stall;
        issue(OP_R, 7'd1, 3'b101, 32'h0, 32'd0, 32'd100, 32'd7, 1'b0, 32'h4);
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if (e_valid !== 1'b0 || e_to_m_valid !== 1'b0 || e_allow_in !== 1'b1)
            $display("FAIL mid_div_reset: got valid=%b to_m=%b allow=%b want 0/0/1", e_valid, e_to_m_valid, e_allow_in);
        else pass_cnt++;
        issue(OP_R, 7'd1, 3'b101, 32'h0, 32'd0, 32'd9, 32'd3, 1'b0, 32'h4);
        wait_stall(stall);
        total_cnt++;
        if (stall !== 33 || e_valE !== 32'd3)
            $display("FAIL divu_after_reset: got stall=%0d val=%h want 33/00000003", stall, e_valE);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_mul();
        test_branch();
        test_div();
        test_back_to_back();
        test_reset_mid_div();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
